// File: rtl/bitrev_read_stream.sv
// Bit-reverse read stream: tags bank read data with frame index/sop/eop and buffers it in a small ready/valid FIFO.
// Optional sticky overflow flag built only when BITREV_OVF_DET_EN is defined.
module bitrev_read_stream #(
  parameter int DWIDTH     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       i_point,
  input  logic              i_rvalid,
  input  logic              i_bank_sel,
  input  logic [DWIDTH-1:0] i_rdata0,
  input  logic [DWIDTH-1:0] i_rdata1,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_sop,
  output logic              o_eop,
  output logic [9:0]        o_index,
  output logic              o_overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [9:0]        index;
    logic [DWIDTH-1:0] data;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [9:0]    idx;
  logic [10:0]   frame_len;

  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic [10:0]   cur_len;
  logic          cap_eop;
  entry_t        cap_entry;
  entry_t        head;

  // A frame's length is taken from i_point at its first sample, so index 0 uses the live value.
  always_comb begin
    full      = (count == FULL_CNT);
    empty     = (count == '0);
    pop       = !empty && i_ready;
    push      = i_rvalid && (!full || pop);
    cur_len   = (idx == '0) ? i_point : frame_len;
    cap_eop   = ({1'b0, idx} == (cur_len - 11'd1));
    cap_entry.sop   = (idx == '0);
    cap_entry.eop   = cap_eop;
    cap_entry.index = idx;
    cap_entry.data  = i_bank_sel ? i_rdata1 : i_rdata0;
  end

  // Index counter advances on every captured sample, dropped or not, to keep framing intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      frame_len <= 11'd1024;
    end else if (i_rvalid) begin
      if (idx == '0)
        frame_len <= i_point;
      idx <= cap_eop ? '0 : idx + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= cap_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Head fields are gated so an empty FIFO presents all-zero outputs.
  always_comb begin
    head    = mem[rd_ptr];
    o_valid = !empty;
    o_data  = '0;
    o_sop   = 1'b0;
    o_eop   = 1'b0;
    o_index = '0;
    if (!empty) begin
      o_data  = head.data;
      o_sop   = head.sop;
      o_eop   = head.eop;
      o_index = head.index;
    end
  end

`ifdef BITREV_OVF_DET_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (reset)
      ovf_q <= 1'b0;
    else if (i_rvalid && full && !pop)
      ovf_q <= 1'b1;
  end
  assign o_overflow = ovf_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bitrev_read_stream.sv
// Directed and random stimulus against a queue-based reference model of bitrev_read_stream.
module tb_bitrev_read_stream;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [10:0]   i_point = 11'd8;
  logic          i_rvalid = 1'b0;
  logic          i_bank_sel = 1'b0;
  logic [DW-1:0] i_rdata0 = '0;
  logic [DW-1:0] i_rdata1 = '0;
  logic          i_ready = 1'b1;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_sop;
  logic          o_eop;
  logic [9:0]    o_index;
  logic          o_overflow;

  bitrev_read_stream #(.DWIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .i_point(i_point), .i_rvalid(i_rvalid),
    .i_bank_sel(i_bank_sel), .i_rdata0(i_rdata0), .i_rdata1(i_rdata1),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_sop(o_sop),
    .o_eop(o_eop), .o_index(o_index), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            sop;
    bit            eop;
    int            index;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];
  int   m_idx  = 0;
  int   m_flen = 1024;
  bit   m_ovf  = 0;
  int   total  = 0;
  int   bad    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, compare just after it.
  task automatic step(input bit rst, input bit rv, input bit bs, input bit rdy, input int pt);
    bit   do_pop;
    bit   do_push;
    int   eff;
    ent_t e;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    d0 = $urandom;
    d1 = $urandom;
    reset = rst; i_rvalid = rv; i_bank_sel = bs; i_ready = rdy;
    i_point = 11'(pt); i_rdata0 = d0; i_rdata1 = d1;
    @(posedge clk);
    do_push = 0;
    if (rst) begin
      q.delete(); m_idx = 0; m_flen = 1024; m_ovf = 0;
    end else begin
      do_pop = (q.size() > 0) && rdy;
      if (rv) begin
        eff = (m_idx == 0) ? pt : m_flen;
        if (m_idx == 0) m_flen = pt;
        e.sop = (m_idx == 0);
        e.eop = (m_idx + 1 == eff);
        e.index = m_idx;
        e.data = bs ? d1 : d0;
        if (q.size() < DEPTH || do_pop) do_push = 1;
        else m_ovf = 1;
        m_idx = (m_idx + 1) % eff;
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    #1;
    chk("valid", 64'(o_valid), 64'(q.size() != 0));
`ifdef BITREV_OVF_DET_EN
    chk("overflow", 64'(o_overflow), 64'(m_ovf));
`else
    chk("overflow", 64'(o_overflow), 64'(0));
`endif
    if (q.size() != 0) begin
      chk("data", 64'(o_data), 64'(q[0].data));
      chk("sop", 64'(o_sop), 64'(q[0].sop));
      chk("eop", 64'(o_eop), 64'(q[0].eop));
      chk("index", 64'(o_index), 64'(q[0].index));
    end else if (rst) begin
      chk("rst_data", 64'(o_data), 64'(0));
      chk("rst_sop", 64'(o_sop), 64'(0));
      chk("rst_eop", 64'(o_eop), 64'(0));
      chk("rst_index", 64'(o_index), 64'(0));
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) step(1, 0, 0, 1, 8);
  endtask

  initial begin
    do_reset();

    // Point 8, alternating banks, ready held high.
    for (int i = 0; i < 8; i++) step(0, 1, i[0], 1, 8);
    step(0, 0, 0, 1, 8);

    // Two back-to-back frames of 16.
    for (int i = 0; i < 32; i++) step(0, 1, i[0], 1, 16);
    step(0, 0, 0, 1, 16);

    // Stall with six captures into a four-entry FIFO, then drain and capture once more.
    for (int i = 0; i < 6; i++) step(0, 1, i[0], 0, 8);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8);
    step(0, 1, 1, 1, 8);
    chk("next_cap_index", 64'(o_index), 64'(6));
    step(0, 0, 0, 1, 8);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8);
    step(0, 1, 1, 1, 8);
    step(0, 0, 0, 0, 8);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8);

    // Length change mid-frame only applies to the next frame.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 8);
    for (int i = 0; i < 9; i++) step(0, 1, 1, 1, 4);
    step(0, 0, 0, 1, 4);

    // Smallest frame length.
    for (int i = 0; i < 5; i++) step(0, 1, i[0], 1, 2);
    step(0, 0, 0, 1, 2);

    // Reset with three entries buffered.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8);
    step(1, 0, 0, 0, 8);
    step(0, 1, 1, 1, 8);
    chk("post_rst_sop", 64'(o_sop), 64'(1));
    step(0, 0, 0, 1, 8);

    // Random traffic with occasional length changes.
    begin
      int pt;
      pt = 8;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 39) == 0) pt = 1 << $urandom_range(1, 5);
        step(0, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) < 7, pt);
      end
      for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 1, pt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
